// File: rtl/pipe_latch_pkg.sv
// Shared pipeline-stage definitions: occupancy states, per-stage bundle
// widths and control-bundle bit positions.
package pipe_latch_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Default bundle widths for each classic stage boundary.
  localparam int unsigned IF_ID_CTRL_W = 1;
  localparam int unsigned IF_ID_DATA_W = 64;
  localparam int unsigned ID_EX_CTRL_W = 9;
  localparam int unsigned ID_EX_DATA_W = 143;
  localparam int unsigned EX_M_CTRL_W  = 5;
  localparam int unsigned EX_M_DATA_W  = 104;
  localparam int unsigned M_WB_CTRL_W  = 2;
  localparam int unsigned M_WB_DATA_W  = 71;

  localparam int unsigned CTRL_MEM_READ   = 0;
  localparam int unsigned CTRL_MEM_WRITE  = 1;
  localparam int unsigned CTRL_BRANCH     = 2;
  localparam int unsigned CTRL_REG_WRITE  = 3;
  localparam int unsigned CTRL_MEM_TO_REG = 4;

  function automatic logic [1:0] occ_of(input state_e s);
    logic [1:0] occ;
    case (s)
      ST_EMPTY: occ = 2'd0;
      ST_ONE:   occ = 2'd1;
      ST_TWO:   occ = 2'd2;
      default:  occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_latch_reg.sv
// Register pair for one latch entry: control bits clear to zero on request,
// data bits only ever load so a bubble leaves stale data behind.
module pipe_latch_reg
  import pipe_latch_pkg::*;
#(
  parameter int unsigned CTRL_W = EX_M_CTRL_W,
  parameter int unsigned DATA_W = EX_M_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld,
  input  logic              clr,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic [CTRL_W-1:0] ctrl_d, ctrl_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Next-state selection: clear wins over load.
  always_comb begin
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (clr) begin
      ctrl_d = {CTRL_W{1'b0}};
    end else if (ld) begin
      ctrl_d = ctrl_i;
      data_d = data_i;
    end else begin
      ctrl_d = ctrl_q;
      data_d = data_q;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= {CTRL_W{1'b0}};
      data_q <= {DATA_W{1'b0}};
    end else begin
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  assign ctrl_o = ctrl_q;
  assign data_o = data_q;

endmodule

// File: rtl/pipe_latch.sv
// Pipeline-stage latch with valid/ready handshake, optional two-entry skid
// buffer, flush, and a control bundle that reads as NOP whenever empty.
module pipe_latch
  import pipe_latch_pkg::*;
#(
  parameter int unsigned CTRL_W = EX_M_CTRL_W,
  parameter int unsigned DATA_W = EX_M_DATA_W,
  parameter int unsigned SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  state_e            state_d, state_q;
  logic              in_ready_d, in_ready_q;
  logic              out_valid_d, out_valid_q;
  logic [1:0]        occ_d, occ_q;

  logic              push, pop;
  logic              main_ld, main_clr, main_from_skid;
  logic              skid_ld, skid_clr;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  // Without a skid entry the stage can only accept when the head leaves.
  assign in_ready = (SKID != 0) ? in_ready_q : (!out_valid_q | out_ready);
  assign push     = in_valid & in_ready;
  assign pop      = out_valid_q & out_ready;

  // Occupancy FSM next state and register-pair controls.
  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_ld        = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      state_d  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end else if (push) begin
            state_d = ST_TWO;
            skid_ld = 1'b1;
          end else if (pop) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop) begin
            state_d        = ST_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d  = ST_EMPTY;
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
    occ_d       = occ_of(state_d);
  end

  // Head reload source: skid entry when draining TWO, otherwise the input.
  always_comb begin
    if (main_from_skid) begin
      main_ctrl_in = skid_ctrl;
      main_data_in = skid_data;
    end else begin
      main_ctrl_in = in_ctrl;
      main_data_in = in_data;
    end
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      occ_q       <= occ_d;
    end
  end

  pipe_latch_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (main_ld),
    .clr    (main_clr),
    .ctrl_i (main_ctrl_in),
    .data_i (main_data_in),
    .ctrl_o (main_ctrl),
    .data_o (main_data)
  );

  pipe_latch_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .ld     (skid_ld),
    .clr    (skid_clr),
    .ctrl_i (in_ctrl),
    .data_i (in_data),
    .ctrl_o (skid_ctrl),
    .data_o (skid_data)
  );

  assign out_valid = out_valid_q;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_latch.sv
// Directed bench for pipe_latch: one instance per SKID mode, checked with
// immediate assertions against hand-computed values.
module tb_pipe_latch;

  localparam int CW = 5;
  localparam int DW = 104;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          iv1, fl1, or1, ir1, ov1;
  logic [CW-1:0] ic1, oc1;
  logic [DW-1:0] id1, od1;
  logic [1:0]    occ1;
  logic          iv0, fl0, or0, ir0, ov0;
  logic [CW-1:0] ic0, oc0;
  logic [DW-1:0] id0, od0;
  logic [1:0]    occ0;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_latch #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_ctrl(ic1),
    .in_data(id1), .flush(fl1), .out_valid(ov1), .out_ready(or1),
    .out_ctrl(oc1), .out_data(od1), .occupancy(occ1)
  );

  pipe_latch #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_ctrl(ic0),
    .in_data(id0), .flush(fl0), .out_valid(ov0), .out_ready(or0),
    .out_ctrl(oc0), .out_data(od0), .occupancy(occ0)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b0; ic1 = '0; id1 = '0;
    iv0 = 1'b0; fl0 = 1'b0; or0 = 1'b0; ic0 = '0; id0 = '0;
    #12;
    chk("rst_out_valid", ov1, 0);
    chk("rst_out_ctrl", oc1, 0);
    chk("rst_out_data", od1, 0);
    chk("rst_in_ready", ir1, 1);
    chk("rst_occ", occ1, 0);
    chk("rst_s0_in_ready", ir0, 1);
    chk("rst_s0_out_valid", ov0, 0);
    rst_n = 1'b1;
    tick();

    // single pass
    iv1 = 1'b1; ic1 = 5'b11111; id1 = 104'd1; or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    chk("pass_valid", ov1, 1);
    chk("pass_ctrl", oc1, 5'b11111);
    chk("pass_data", od1, 1);
    chk("pass_occ", occ1, 1);
    tick();
    chk("pass_drain_valid", ov1, 0);
    chk("pass_drain_ctrl", oc1, 0);

    // backpressure fill
    or1 = 1'b0; iv1 = 1'b1; ic1 = 5'b00011; id1 = 104'h10;
    tick();
    id1 = 104'h20;
    tick();
    iv1 = 1'b0;
    chk("bp_occ2", occ1, 2);
    chk("bp_in_ready0", ir1, 0);
    chk("bp_head_a", od1, 104'h10);
    tick();
    chk("bp_hold_a", od1, 104'h10);
    chk("bp_hold_occ", occ1, 2);
    or1 = 1'b1;
    tick();
    chk("bp_head_b", od1, 104'h20);
    chk("bp_in_ready1", ir1, 1);
    chk("bp_occ1", occ1, 1);
    tick();
    chk("bp_empty", ov1, 0);

    // streaming, both modes
    iv1 = 1'b1; or1 = 1'b1; iv0 = 1'b1; or0 = 1'b1;
    ic1 = 5'b00001; ic0 = 5'b00001;
    for (int i = 0; i < 8; i++) begin
      id1 = DW'(i); id0 = DW'(i);
      tick();
      chk("s1_stream_data", od1, i);
      chk("s1_stream_valid", ov1, 1);
      chk("s1_stream_occ", occ1, 1);
      chk("s0_stream_data", od0, i);
      chk("s0_stream_valid", ov0, 1);
      chk("s0_stream_occ", occ0, 1);
    end
    iv1 = 1'b0; iv0 = 1'b0;
    tick();
    chk("s1_stream_end", ov1, 0);
    chk("s0_stream_end", ov0, 0);

    // flush in TWO with an entry offered
    or1 = 1'b0; iv1 = 1'b1; ic1 = 5'b00100; id1 = 104'h50;
    tick();
    id1 = 104'h60;
    tick();
    chk("fl_pre_occ", occ1, 2);
    id1 = 104'h30; fl1 = 1'b1;
    tick();
    fl1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;
    chk("fl_occ", occ1, 0);
    chk("fl_valid", ov1, 0);
    chk("fl_ctrl", oc1, 0);
    chk("fl_in_ready", ir1, 1);
    tick();
    chk("fl_no_c", ov1, 0);

    // flush in ONE drops an accepted-looking input
    or1 = 1'b0; iv1 = 1'b1; id1 = 104'h70;
    tick();
    id1 = 104'h30; fl1 = 1'b1;
    tick();
    fl1 = 1'b0; iv1 = 1'b0;
    chk("fl1_valid", ov1, 0);
    chk("fl1_occ", occ1, 0);
    tick();
    chk("fl1_still_empty", ov1, 0);

    // async reset while full
    iv1 = 1'b1; ic1 = 5'b01010; id1 = 104'h80;
    tick();
    id1 = 104'h90;
    tick();
    iv1 = 1'b0;
    chk("ar_pre_occ", occ1, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", ov1, 0);
    chk("ar_occ", occ1, 0);
    chk("ar_ctrl", oc1, 0);
    chk("ar_data", od1, 0);
    chk("ar_in_ready", ir1, 1);
    #2 rst_n = 1'b1;
    iv1 = 1'b1; ic1 = 5'b11111; id1 = 104'h40; or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    chk("ar_d_valid", ov1, 1);
    chk("ar_d_data", od1, 104'h40);
    tick();
    chk("ar_d_only", ov1, 0);

    // SKID=0 combinational in_ready and replace-on-pop
    iv0 = 1'b1; ic0 = 5'b00010; id0 = 104'hA1; or0 = 1'b0;
    tick();
    chk("s0_head_a1", od0, 104'hA1);
    chk("s0_in_ready0", ir0, 0);
    tick();
    chk("s0_hold_a1", od0, 104'hA1);
    or0 = 1'b1; id0 = 104'hA2;
    #1;
    chk("s0_in_ready1", ir0, 1);
    tick();
    iv0 = 1'b0;
    chk("s0_replace", od0, 104'hA2);
    chk("s0_replace_occ", occ0, 1);
    tick();
    chk("s0_empty", ov0, 0);
    chk("s0_empty_ctrl", oc0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_latch.md
# pipe_latch

Parametrised pipeline-stage register with valid/ready flow control, a two-entry skid buffer, synchronous flush and bubble insertion. It is the generic successor to the fixed-field stage latches. It sits between any two pipeline stages (IF/ID, ID/EX, EX/M, M/WB) and carries a control bundle plus a data bundle. The control bundle is forced to zero whenever the stage holds no valid instruction, so a bubble is always a NOP.

## Interface
Parameters:
- CTRL_W, 5, width of control bundle (mem_to_reg, reg_write, branch, mem_write, mem_read); zeroed on bubble.
- DATA_W, 104, width of data bundle (pc_branch, zero, alu_result, data2, dst); not zeroed on bubble.
- SKID, 1. 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  stage clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept an entry this cycle.
- in_ctrl  in  CTRL_W  control bundle.
- in_data  in  DATA_W  data bundle.
- flush  in  1  discard all held entries (branch taken / exception).
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts the head entry this cycle.
- out_ctrl  out  CTRL_W  head control; all-zero when out_valid=0.
- out_data  out  DATA_W  head data; don't-care when out_valid=0.
- occupancy  out  2  number of held entries (0..2).

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Storage is a main register (head) and a skid register. FIFO order is always preserved.
- States (SKID=1):
  - EMPTY, occ 0: push -> ONE, main loaded.
  - ONE, occ 1:
    - push & pop -> ONE, main reloaded with input.
    - push & !pop -> TWO, skid loaded.
    - pop & !push -> EMPTY.
    - neither -> hold.
  - TWO, occ 2: in_ready=0. pop -> ONE, main <- skid. No pop -> hold.
- SKID=0: only EMPTY/ONE exist.
  - in_ready = !out_valid | out_ready, combinational.
  - push & pop reloads main.
- flush has priority over push and pop. Next state is EMPTY, both valid bits clear, ctrl registers clear. An input offered in the flush cycle is dropped, even if in_ready=1. The data registers keep their contents.
- out_ctrl is driven from a register cleared on every transition to the empty head; it is not masked combinationally.

## Timing
- Reset values:
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0.
  - in_ready=1 (SKID=1). For SKID=0, in_ready follows its equation, which gives 1.
  - Internal state EMPTY; skid register 0.
- Latency is 1 cycle: an entry pushed at edge N is on out_* after edge N with out_valid=1.
- Throughput is 1 entry/cycle while out_ready=1, in both modes.
- SKID=1: in_ready is a register. in_ready=0 only in TWO and rises the cycle after a pop from TWO.
- Upstream must hold in_ctrl/in_data stable while in_valid & !in_ready. Downstream sees out_* stable while out_valid & !out_ready.
- rst_n asserted mid-transfer clears everything immediately (async). The first push is possible on the first rising edge after deassertion.
- flush together with out_ready: the head is consumed downstream this cycle (combinational pop). The stage is still EMPTY next cycle.

## Structure
- Shared pipeline package:
  - state enum {EMPTY, ONE, TWO};
  - default CTRL_W/DATA_W per stage (IF_ID, ID_EX, EX_M, M_WB);
  - control-bundle bit index constants.
- Natural sub-module: pipe_latch_reg. It is an async-reset register pair (ctrl clearable, data load-only) used twice for main and skid.
- The FSM and the valid/ready logic live in pipe_latch.

## Test plan
- Reset and single pass:
  - After reset: out_valid=0, out_ctrl=0, in_ready=1.
  - Push ctrl=5'b11111, data=1 with out_ready=1 -> next cycle out_valid=1, out_ctrl=5'b11111, out_data=1, occupancy=1.
- Backpressure fill (SKID=1), out_ready=0:
  - push A=0x10, then B=0x20 -> occupancy=2, in_ready=0, out_data=0x10.
  - Raise out_ready -> 0x10 then 0x20 on consecutive cycles; in_ready returns to 1 the cycle after the first pop.
- Streaming, in_valid=out_ready=1 for 8 cycles with data 0..7 -> outputs 0..7 in order, one per cycle, no gap, occupancy=1 throughout, both SKID modes.
- Flush in TWO with push of C=0x30 offered -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x30 never appears on the output.
- Async reset: assert rst_n=0 mid-cycle while occupancy=2 -> outputs clear before the next edge. After release, push D=0x40 -> D is the only entry emitted.
- SKID=0, out_valid=1, out_ready=0 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally, and push & pop replaces the head.
